// File: rtl/seq_stream_ctrl_pkg.sv
// Shared definitions for the word-to-bit pattern detection controller:
// default sizes and the controller FSM encoding.
package seq_stream_ctrl_pkg;

  localparam int DEF_WORD_W = 8;
  localparam int DEF_PAT_W  = 4;
  localparam int DEF_CNT_W  = 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_REPORT
  } state_t;

endpackage

// File: rtl/seq_pattern_matcher.sv
// Overlapping bit-serial pattern matcher. Holds a PAT_W-bit history and a
// saturating count of bits seen since reset/clear; match is combinational.
module seq_pattern_matcher
  import seq_stream_ctrl_pkg::*;
#(
  parameter int PAT_W = DEF_PAT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             bit_valid,
  input  logic             bit_in,
  input  logic [PAT_W-1:0] pattern,
  output logic             match
);

  localparam int SEEN_W = $clog2(PAT_W + 1);

  logic [PAT_W-1:0]  hist;
  logic [PAT_W-1:0]  hist_next;
  logic [SEEN_W-1:0] seen;

  assign hist_next = {hist[PAT_W-2:0], bit_in};

  // seen >= PAT_W after this shift means at least PAT_W-1 real bits already
  // held, so zeros left over from reset/clear can never complete a match.
  assign match = bit_valid && (hist_next == pattern) && (seen >= SEEN_W'(PAT_W - 1));

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      hist <= '0;
      seen <= '0;
    end else if (bit_valid) begin
      // NOTE: non-blocking so hist and seen both update from pre-edge values.
      hist <= hist_next;
      if (seen != SEEN_W'(PAT_W)) seen <= seen + SEEN_W'(1);
    end
  end

endmodule

// File: rtl/seq_stream_ctrl.sv
// Accepts words over valid/ready, serializes them MSB-first into the pattern
// matcher, and keeps per-word and saturating total match counts plus irq.
module seq_stream_ctrl
  import seq_stream_ctrl_pkg::*;
#(
  parameter int WORD_W = DEF_WORD_W,
  parameter int PAT_W  = DEF_PAT_W,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         enable,
  input  logic                         clear,
  input  logic [PAT_W-1:0]             cfg_pattern,
  input  logic [CNT_W-1:0]             cfg_threshold,
  input  logic                         in_valid,
  input  logic [WORD_W-1:0]            in_data,
  output logic                         in_ready,
  output logic                         match_pulse,
  output logic                         word_done,
  output logic [$clog2(WORD_W+1)-1:0]  word_match_cnt,
  output logic [CNT_W-1:0]             total_cnt,
  output logic                         irq
);

  localparam int IDX_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam int WC_W  = $clog2(WORD_W + 1);

  state_t             state;
  logic [WORD_W-1:0]  data_q;
  logic [PAT_W-1:0]   pattern_q;
  logic [IDX_W-1:0]   bit_idx;
  logic               bit_valid;
  logic               bit_in;
  logic               match;
  logic [CNT_W-1:0]   total_next;

  assign bit_valid = (state == ST_SHIFT);
  assign bit_in    = data_q[bit_idx];
  assign in_ready  = (state == ST_IDLE) && enable;

  seq_pattern_matcher #(
    .PAT_W (PAT_W)
  ) u_matcher (
    .clk       (clk),
    .rst       (rst),
    .clr       (clear),
    .bit_valid (bit_valid),
    .bit_in    (bit_in),
    .pattern   (pattern_q),
    .match     (match)
  );

  always_comb begin
    // NOTE: default first so every path assigns total_next and no latch forms.
    total_next = total_cnt;
    if (match && (total_cnt != {CNT_W{1'b1}})) total_next = total_cnt + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      state          <= ST_IDLE;
      data_q         <= '0;
      pattern_q      <= '0;
      bit_idx        <= '0;
      match_pulse    <= 1'b0;
      word_done      <= 1'b0;
      word_match_cnt <= '0;
      total_cnt      <= '0;
      irq            <= 1'b0;
    end else begin
      match_pulse <= match;
      word_done   <= 1'b0;
      total_cnt   <= total_next;
      if (match) word_match_cnt <= word_match_cnt + WC_W'(1);
      // Compared against the live threshold, so lowering it below the
      // current total raises irq on the next edge.
      if ((cfg_threshold != '0) && (total_next >= cfg_threshold)) irq <= 1'b1;

      case (state)
        ST_IDLE: begin
          if (in_valid && in_ready) begin
            data_q         <= in_data;
            pattern_q      <= cfg_pattern;
            word_match_cnt <= '0;
            bit_idx        <= IDX_W'(WORD_W - 1);
            state          <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          bit_idx <= bit_idx - IDX_W'(1);
          if (bit_idx == '0) begin
            state     <= ST_REPORT;
            word_done <= 1'b1;
          end
        end
        ST_REPORT: state <= ST_IDLE;
        default:   state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_stream_ctrl.sv
// Randomized bench for seq_stream_ctrl: a bit-stream/window model predicts
// pulse cycles, counts and irq from the word-level timing rules.
module tb_seq_stream_ctrl;

  localparam int WORD_W  = 8;
  localparam int PAT_W   = 4;
  localparam int CNT_W   = 6;
  localparam int WC_W    = $clog2(WORD_W + 1);
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              rst, enable, clear, in_valid;
  logic [PAT_W-1:0]  cfg_pattern;
  logic [CNT_W-1:0]  cfg_threshold;
  logic [WORD_W-1:0] in_data;
  logic              in_ready, match_pulse, word_done, irq;
  logic [WC_W-1:0]   word_match_cnt;
  logic [CNT_W-1:0]  total_cnt;

  int total_checks = 0;
  int bad_checks   = 0;

  bit hist_q[$];
  int m_total, m_word;
  bit m_irq;

  always #5 clk = ~clk;

  seq_stream_ctrl #(
    .WORD_W (WORD_W),
    .PAT_W  (PAT_W),
    .CNT_W  (CNT_W)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .enable         (enable),
    .clear          (clear),
    .cfg_pattern    (cfg_pattern),
    .cfg_threshold  (cfg_threshold),
    .in_valid       (in_valid),
    .in_data        (in_data),
    .in_ready       (in_ready),
    .match_pulse    (match_pulse),
    .word_done      (word_done),
    .word_match_cnt (word_match_cnt),
    .total_cnt      (total_cnt),
    .irq            (irq)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_checks++;
    if (got !== exp) begin
      bad_checks++;
      $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic void model_reset();
    hist_q.delete();
    m_total = 0;
    m_word  = 0;
    m_irq   = 1'b0;
  endfunction

  // Append one bit to the received stream; a match is the last PAT_W bits
  // read as a number equal to the pattern.
  function automatic bit model_feed(input bit b, input logic [PAT_W-1:0] p);
    int v = 0;
    hist_q.push_back(b);
    if (hist_q.size() > PAT_W) void'(hist_q.pop_front());
    foreach (hist_q[i]) v = (v << 1) | int'(hist_q[i]);
    return (hist_q.size() == PAT_W) && (v == int'(p));
  endfunction

  // Effect of one clock edge on the counters given whether a pulse follows it.
  function automatic void model_count(input bit pulse);
    if (pulse) begin
      m_word++;
      if (m_total < CNT_MAX) m_total++;
    end
    if ((cfg_threshold != 0) && (m_total >= int'(cfg_threshold))) m_irq = 1'b1;
  endfunction

  task automatic check_outputs(input string tag, input bit exp_p, input bit exp_d, input bit exp_r);
    check({tag, ".pulse"}, match_pulse, exp_p);
    check({tag, ".done"},  word_done,   exp_d);
    check({tag, ".ready"}, in_ready,    exp_r);
    check({tag, ".word"},  word_match_cnt, m_word);
    check({tag, ".total"}, total_cnt,   m_total);
    check({tag, ".irq"},   irq,         m_irq);
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    model_reset();
    check_outputs("clear", 1'b0, 1'b0, enable);
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      tick();
      model_count(1'b0);
      check_outputs("idle", 1'b0, 1'b0, enable);
    end
  endtask

  // Present a word at the current negedge; handshake on the next edge (end of
  // cycle T); then check cycles T+1..T+WORD_W+2. clear_at>0 aborts after that cycle.
  task automatic run_word(input string tag, input logic [WORD_W-1:0] d,
                          input logic [PAT_W-1:0] p, input bit drop_en, input int clear_at);
    bit mt[WORD_W+3];
    foreach (mt[i]) mt[i] = 1'b0;
    enable   = 1'b1;
    in_valid = 1'b1;
    in_data  = d;
    cfg_pattern = p;
    #1;
    check({tag, ".ready_pre"}, in_ready, 1'b1);
    for (int k = 1; k <= WORD_W; k++) mt[k+1] = model_feed(d[WORD_W-k], p);
    for (int c = 1; c <= WORD_W + 2; c++) begin
      tick();
      if (c == 1) m_word = 0;
      model_count(mt[c]);
      check_outputs(tag, mt[c], c == WORD_W + 1, (c == WORD_W + 2) && !drop_en);
      if (c == 1) begin
        in_valid    = drop_en;
        in_data     = WORD_W'($urandom);
        cfg_pattern = PAT_W'($urandom);
      end
      if (c == 2 && drop_en) enable = 1'b0;
      if (c == clear_at) begin
        clear = 1'b1;
        tick();
        clear = 1'b0;
        model_reset();
        check_outputs({tag, ".abort"}, 1'b0, 1'b0, 1'b1);
        break;
      end
    end
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; clear = 1'b0; in_valid = 1'b0;
    in_data = '0; cfg_pattern = '0; cfg_threshold = '0;
    model_reset();
    repeat (3) tick();
    rst = 1'b0;
    check_outputs("reset", 1'b0, 1'b0, 1'b0);
    enable = 1'b1;
    idle(2);

    run_word("b6", 8'hB6, 4'b1011, 1'b0, 0);

    do_clear();
    run_word("span1", 8'h05, 4'b1011, 1'b0, 0);
    run_word("span2", 8'h80, 4'b1011, 1'b0, 0);

    do_clear();
    run_word("zeros", 8'h00, 4'b0000, 1'b0, 0);

    do_clear();
    cfg_threshold = 6'd3;
    run_word("thr1", 8'hB6, 4'b1011, 1'b0, 0);
    run_word("thr2", 8'hB6, 4'b1011, 1'b0, 0);
    idle(2);

    do_clear();
    run_word("abort", 8'hB6, 4'b1011, 1'b0, 3);
    run_word("after", 8'h0B, 4'b1011, 1'b0, 0);

    in_data = 8'h5A; in_valid = 1'b1; enable = 1'b0;
    repeat (5) begin
      tick();
      model_count(1'b0);
      check_outputs("en_off", 1'b0, 1'b0, 1'b0);
    end
    run_word("en_drop", 8'hDB, 4'b1101, 1'b1, 0);
    repeat (3) begin
      tick();
      model_count(1'b0);
      check_outputs("en_hold", 1'b0, 1'b0, 1'b0);
    end
    in_valid = 1'b0;
    enable   = 1'b1;
    idle(1);

    for (int n = 0; n < 60; n++) begin
      logic [WORD_W-1:0] d;
      logic [PAT_W-1:0]  p;
      d = WORD_W'($urandom);
      p = PAT_W'($urandom);
      if ($urandom_range(0, 9) < 3) begin
        d = '0;
        p = '0;
      end
      if ($urandom_range(0, 9) == 0) cfg_threshold = CNT_W'($urandom_range(0, CNT_MAX));
      idle($urandom_range(0, 3));
      run_word("rnd", d, p, 1'b0, ($urandom_range(0, 19) == 0) ? $urandom_range(1, WORD_W + 1) : 0);
    end
    cfg_threshold = CNT_W'(1);
    idle(2);

    $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
    $finish;
  end

endmodule
